// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data-cache controller: default
// geometry, derived line/tag sizes and the controller FSM encoding.
package dcache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int INDEX_BITS = 5;
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int NUM_LINES  = 2 ** INDEX_BITS;

  // IDLE serves hits and accepts requests; the other two own the memory bus.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_MEM  = 2'd2
  } state_e;

endpackage : dcache_pkg

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: per-line valid bit, tag and data.
// One asynchronous read port, one synchronous write port. Only the valid bits
// are reset; tag and data contents are meaningless until a line is valid.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_W  = INDEX_BITS,
  parameter int TAG_W  = TAG_BITS,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Any write to a line makes it valid (fill, or data update of a hit line).
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  // Valid bits clear asynchronously so a reset invalidates the whole cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: tag/data arrays have no reset; clearing them would force flops
  // instead of RAM, and the valid bits already mask their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule : dcache_array

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Read hits return data combinationally with no stall; read misses and all
// stores stall the core while the request is carried out on the memory bus.
module dcache_wt_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = dcache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dcache_pkg::DATA_WIDTH,
  parameter int INDEX_BITS = dcache_pkg::INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;   // latched word address
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_W-1:0]      lk_tag;
  logic                  arr_valid;
  logic [TAG_W-1:0]      arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  hit;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_wdata;

  // Byte-offset bits never matter to a word-granular cache.
  logic unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[1:0];

  // Lookup address: the live CPU address while idle, the latched store
  // address while writing through (to decide whether to update the line).
  always_comb begin
    if (state_q == ST_IDLE) begin
      lk_index = cpu_addr[INDEX_BITS+1:2];
      lk_tag   = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    end else begin
      lk_index = addr_q[INDEX_BITS-1:0];
      lk_tag   = addr_q[ADDR_WIDTH-3:INDEX_BITS];
    end
  end

  assign hit = arr_valid && (arr_tag == lk_tag);

  dcache_array #(
    .IDX_W  (INDEX_BITS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (lk_index),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (arr_we),
    .wr_index (addr_q[INDEX_BITS-1:0]),
    .wr_tag   (addr_q[ADDR_WIDTH-3:INDEX_BITS]),
    .wr_data  (arr_wdata)
  );

  // Memory-side outputs depend only on state and latched registers.
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state_q == ST_RD_MISS);
  assign mem_wr    = (state_q == ST_WR_MEM);

  // Next-state, latch capture, stall, load data and line-update control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall     = 1'b0;
    cpu_rdata = '0;
    arr_we    = 1'b0;
    arr_wdata = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_wr) begin
          // Store wins over a simultaneous load.
          addr_d  = cpu_addr[ADDR_WIDTH-1:2];
          wdata_d = cpu_wdata;
          stall   = 1'b1;
          state_d = ST_WR_MEM;
        end else if (cpu_rd && !hit) begin
          addr_d  = cpu_addr[ADDR_WIDTH-1:2];
          stall   = 1'b1;
          state_d = ST_RD_MISS;
        end else if (cpu_rd) begin
          cpu_rdata = arr_data;
        end
      end

      ST_RD_MISS: begin
        if (mem_ready) begin
          // Fill the line and forward the word so the core advances now.
          arr_we    = 1'b1;
          arr_wdata = mem_rdata;
          cpu_rdata = mem_rdata;
          state_d   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      ST_WR_MEM: begin
        if (mem_ready) begin
          // Keep a resident copy coherent; never allocate on a store miss.
          arr_we  = hit;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request latches; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule : dcache_wt_ctrl

// File: tb/tb_dcache_wt_ctrl.sv
// Self-checking bench for dcache_wt_ctrl: directed vector table, hand-written
// reset sequences, and randomized traffic checked against a cache/memory model.
module tb_dcache_wt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_rd, cpu_wr, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;

  int vectors = 0;
  int errors  = 0;

  dcache_wt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // exp_mem: 0 = read hit (no bus traffic), 1 = memory read, 2 = memory write.
  // exp_cyc: cycles the request occupies the core, 1 for a hit, else 1 + N.
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    int          exp_mem;
  } vec_t;

  vec_t tbl [15];

  // Reference model: cache contents and backing memory.
  bit          ref_valid [32];
  logic [24:0] ref_tag   [32];
  logic [31:0] ref_data  [32];
  logic [31:0] ref_mem   [logic [31:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Present one request at a negedge and follow it to completion, checking
  // every cycle; mem_ready is raised in the exp_cyc-1'th memory cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata,
                        input int exp_cyc, input logic [31:0] exp_rdata,
                        input int exp_mem, input string nm);
    logic [31:0] wa;
    int          cyc;
    int          lat;
    wa  = addr & 32'hFFFF_FFFC;
    lat = exp_cyc - 1;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    check({nm, " c0 mem_rd|mem_wr"}, {31'd0, mem_rd | mem_wr}, 32'd0);
    if (exp_mem == 0) begin
      check({nm, " hit stall"}, {31'd0, stall}, 32'd0);
      check({nm, " hit rdata"}, cpu_rdata, exp_rdata);
    end else begin
      check({nm, " c0 stall"}, {31'd0, stall}, 32'd1);
      cyc = 1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        mem_ready = (k == lat);
        mem_rdata = mem_ready ? mdata : $urandom;
        #1;
        cyc++;
        check({nm, " mem_rd"}, {31'd0, mem_rd}, {31'd0, exp_mem == 1});
        check({nm, " mem_wr"}, {31'd0, mem_wr}, {31'd0, exp_mem == 2});
        check({nm, " mem_addr"}, mem_addr, wa);
        if (exp_mem == 2) check({nm, " mem_wdata"}, mem_wdata, wdata);
        check({nm, " rdata"}, cpu_rdata, (mem_ready && exp_mem == 1) ? exp_rdata : 32'd0);
        if (!stall) break;
      end
      check({nm, " occupancy cycles"}, cyc, exp_cyc);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b0;
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return wa ^ 32'h5A5A_0000;
  endfunction

  // Derive expectations from cache rules, run the request, update the model.
  task automatic model_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input string nm);
    logic [31:0] wa;
    int          idx;
    logic [24:0] tg;
    bit          hit;
    wa  = addr & 32'hFFFF_FFFC;
    idx = int'((wa / 4) % 32);
    tg  = 25'(wa / 128);
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    if (wr) begin
      access(rd, wr, addr, wdata, 32'd0, 1 + lat, 32'd0, 2, nm);
      ref_mem[wa] = wdata;
      if (hit) ref_data[idx] = wdata;
    end else if (hit) begin
      access(rd, wr, addr, wdata, 32'd0, 1, ref_data[idx], 0, nm);
    end else begin
      access(rd, wr, addr, wdata, mem_val(wa), 1 + lat, mem_val(wa), 1, nm);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_data[idx]  = mem_val(wa);
    end
  endtask

  task automatic check_quiet(input string nm);
    check({nm, " cpu_rdata"}, cpu_rdata, 32'd0);
    check({nm, " stall"},     {31'd0, stall},  32'd0);
    check({nm, " mem_addr"},  mem_addr,  32'd0);
    check({nm, " mem_wdata"}, mem_wdata, 32'd0);
    check({nm, " mem_rd"},    {31'd0, mem_rd}, 32'd0);
    check({nm, " mem_wr"},    {31'd0, mem_wr}, 32'd0);
  endtask

  initial begin
    //          rd wr addr          wdata         mdata         cyc rdata        mem
    tbl[0]  = '{1, 0, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1};
    tbl[1]  = '{1, 0, 32'h0000_0040, 32'h0,        32'h0,         1, 32'hDEAD_BEEF, 0};
    tbl[2]  = '{0, 1, 32'h0000_0040, 32'h1234_5678, 32'h0,        3, 32'h0,         2};
    tbl[3]  = '{1, 0, 32'h0000_0040, 32'h0,        32'h0,         1, 32'h1234_5678, 0};
    tbl[4]  = '{0, 1, 32'h0000_0100, 32'hAAAA_5555, 32'h0,        2, 32'h0,         2};
    tbl[5]  = '{1, 0, 32'h0000_0100, 32'h0,        32'hAAAA_5555, 3, 32'hAAAA_5555, 1};
    tbl[6]  = '{1, 0, 32'h0000_00C0, 32'h0,        32'hC0C0_C0C0, 2, 32'hC0C0_C0C0, 1};
    tbl[7]  = '{1, 0, 32'h0000_0040, 32'h0,        32'h1234_5678, 3, 32'h1234_5678, 1};
    tbl[8]  = '{1, 0, 32'h0000_00C0, 32'h0,        32'hC0C0_C0C0, 2, 32'hC0C0_C0C0, 1};
    tbl[9]  = '{1, 1, 32'h0000_0104, 32'h0BAD_F00D, 32'h0,        2, 32'h0,         2};
    tbl[10] = '{1, 0, 32'h0000_0100, 32'h0,        32'h0,         1, 32'hAAAA_5555, 0};
    tbl[11] = '{1, 0, 32'h0000_00C3, 32'h0,        32'h0,         1, 32'hC0C0_C0C0, 0};
    tbl[12] = '{0, 1, 32'h0000_00C2, 32'hFEED_FACE, 32'h0,        5, 32'h0,         2};
    tbl[13] = '{1, 0, 32'h0000_00C0, 32'h0,        32'h0,         1, 32'hFEED_FACE, 0};
    tbl[14] = '{1, 0, 32'h0000_0040, 32'h0,        32'h1234_5678, 2, 32'h1234_5678, 1};

    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // mem_ready during IDLE must be ignored.
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("idle ready stall", {31'd0, stall}, 32'd0);
    check("idle ready mem_rd", {31'd0, mem_rd}, 32'd0);
    mem_ready = 1'b0;

    for (int i = 0; i < 15; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mdata,
             tbl[i].exp_cyc, tbl[i].exp_rdata, tbl[i].exp_mem, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a read miss: request dropped at once.
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0200; mem_ready = 1'b0;
    #1;
    check("rstmid c0 stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check("rstmid mem_rd before", {31'd0, mem_rd}, 32'd1);
    #2;
    rst_n = 1'b0; cpu_rd = 1'b0;
    #1;
    check_quiet("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;

    // Previously filled 0x40 must miss after reset.
    model_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, "post-reset rd 0x40");

    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [24:0] tg;
      logic [31:0] addr;
      op = $urandom_range(0, 3);
      tg = 25'($urandom_range(0, 3));
      if (tg == 25'd3) tg = 25'h1FF_FFFF;
      addr = {tg, 3'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      addr[6:5] = 2'd0;
      model_op(op >= 2 || op == 1, op <= 1, addr, $urandom,
               $urandom_range(1, 4), $sformatf("rand%0d", n));
    end

    go_idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_dcache_wt_ctrl
